// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared mode encodings for the immediate-extension stage.
package imm_ext_pkg;
  localparam int MODE_NBITS = 3;
  localparam logic [MODE_NBITS-1:0] MODE_SEXT   = 3'd0;
  localparam logic [MODE_NBITS-1:0] MODE_ZEXT   = 3'd1;
  localparam logic [MODE_NBITS-1:0] MODE_LUI    = 3'd2;
  localparam logic [MODE_NBITS-1:0] MODE_BRANCH = 3'd3;
  localparam logic [MODE_NBITS-1:0] MODE_JUMP   = 3'd4;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extension for all five modes plus illegal-mode flag.
module imm_ext_core import imm_ext_pkg::*; #(
  parameter int I_NBITS = 16,
  parameter int J_NBITS = 26,
  parameter int O_NBITS = 32,
  parameter int SHIFT   = 2
) (
  input  logic [J_NBITS-1:0]    field,
  input  logic [MODE_NBITS-1:0] mode,
  input  logic [O_NBITS-1:0]    pc,
  output logic [O_NBITS-1:0]    ext,
  output logic                  err
);
  if (J_NBITS < I_NBITS || O_NBITS < I_NBITS + SHIFT || O_NBITS <= J_NBITS + SHIFT) begin : g_illegal
    $error("imm_ext_core: illegal I_NBITS/J_NBITS/O_NBITS/SHIFT combination");
  end
  logic [O_NBITS-1:0] zext, sext, lui, branch, jump, low;
  // Shifts and masks instead of replications so zero-width fills stay legal.
  always_comb begin
    zext   = O_NBITS'(field[I_NBITS-1:0]);
    sext   = zext | ({O_NBITS{field[I_NBITS-1]}} << I_NBITS);
    lui    = zext << (O_NBITS - I_NBITS);
    branch = sext << SHIFT;
    low    = (O_NBITS'(1) << (J_NBITS + SHIFT)) - O_NBITS'(1);
    jump   = (pc & ~low) | (O_NBITS'(field) << SHIFT);
    err    = mode > MODE_JUMP;
    ext    = mode == MODE_SEXT   ? sext   :
             mode == MODE_ZEXT   ? zext   :
             mode == MODE_LUI    ? lui    :
             mode == MODE_BRANCH ? branch :
             mode == MODE_JUMP   ? jump   : '0;
  end
endmodule

// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered immediate extension behind a two-entry skid buffer with flush.
module imm_extend_stage import imm_ext_pkg::*; #(
  parameter int I_NBITS = 16,
  parameter int J_NBITS = 26,
  parameter int O_NBITS = 32,
  parameter int SHIFT   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [J_NBITS-1:0]    i_field,
  input  logic [MODE_NBITS-1:0] i_mode,
  input  logic [O_NBITS-1:0]    i_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [O_NBITS-1:0]    o_ext,
  output logic                  o_err
);
  logic [O_NBITS-1:0] new_ext, skid_ext;
  logic new_err, skid_err, skid_valid, accept, drain;
  imm_ext_core #(.I_NBITS(I_NBITS), .J_NBITS(J_NBITS), .O_NBITS(O_NBITS), .SHIFT(SHIFT)) u_core (
    .field(i_field),
    .mode(i_mode),
    .pc(i_pc),
    .ext(new_ext),
    .err(new_err)
  );
  // Ready depends only on skid occupancy, never on downstream i_ready.
  assign o_ready = ~skid_valid & ~i_reset;
  assign accept  = i_valid & o_ready;
  assign drain   = o_valid & i_ready;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid    <= 1'b0;
      o_ext      <= '0;
      o_err      <= 1'b0;
      skid_valid <= 1'b0;
      skid_ext   <= '0;
      skid_err   <= 1'b0;
    end else if (i_flush) begin
      o_valid    <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!o_valid || drain) begin
      o_valid <= accept | skid_valid;
      if (accept) begin
        o_ext <= new_ext;
        o_err <= new_err;
      end else if (skid_valid) begin
        o_ext      <= skid_ext;
        o_err      <= skid_err;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_ext   <= new_ext;
      skid_err   <= new_err;
    end
  end
endmodule

// File: tb/tb_imm_extend_stage.sv
// tb_imm_extend_stage: directed and random checks of imm_extend_stage against an arithmetic reference.
module tb_imm_extend_stage;
  logic clk = 1'b0;
  logic i_reset = 1'b1, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b1;
  logic [25:0] i_field = '0;
  logic [2:0] i_mode = '0;
  logic [31:0] i_pc = '0;
  logic o_ready, o_valid, o_err;
  logic [31:0] o_ext;
  int checks = 0, errors = 0;
  logic [32:0] sb[$];
  logic hold = 1'b0;
  logic [32:0] held;
  imm_extend_stage dut (
    .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_field(i_field), .i_mode(i_mode), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready),
    .o_ext(o_ext), .o_err(o_err)
  );
  always #5 clk = ~clk;
  function automatic logic [32:0] model(input logic [25:0] f, input logic [2:0] m, input logic [31:0] pc);
    longint imm, s;
    imm = longint'(f) % 65536;
    s = imm >= 32768 ? imm - 65536 : imm;
    case (m)
      3'd0: return {1'b0, 32'(s)};
      3'd1: return {1'b0, 32'(imm)};
      3'd2: return {1'b0, 32'(imm * 65536)};
      3'd3: return {1'b0, 32'(s * 4)};
      3'd4: return {1'b0, 32'((longint'(pc) / 268435456) * 268435456 + longint'(f) * 4)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!i_reset && !i_flush && i_valid && o_ready) sb.push_back(model(i_field, i_mode, i_pc));
  always @(negedge clk) begin
    if (hold) begin
      chk("hold_valid", 64'(o_valid), 64'd1);
      chk("hold_data", 64'({o_err, o_ext}), 64'(held));
    end
    hold = 1'b0;
    if (i_reset || i_flush) sb.delete();
    else if (o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", {o_err, o_ext});
      end else chk("sb_output", 64'({o_err, o_ext}), 64'(sb.pop_front()));
    end else if (o_valid) begin
      hold = 1'b1;
      held = {o_err, o_ext};
    end
  end
  task automatic send(input logic [25:0] f, input logic [2:0] m, input logic [31:0] pc);
    int n = 0;
    i_valid = 1'b1; i_field = f; i_mode = m; i_pc = pc;
    @(negedge clk);
    while (!o_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!o_ready) chk("send_timeout", 64'(o_ready), 64'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask
  task automatic send_chk(input string name, input logic [25:0] f, input logic [2:0] m,
                          input logic [31:0] pc, input logic [32:0] exp);
    send(f, m, pc);
    @(negedge clk);
    chk({name, "_valid"}, 64'(o_valid), 64'd1);
    chk(name, 64'({o_err, o_ext}), 64'(exp));
    @(posedge clk); #1;
  endtask
  task automatic fill_two();
    i_ready = 1'b0;
    send(26'h0001, 3'd0, 32'h0);
    send(26'h0002, 3'd0, 32'h0);
    @(negedge clk);
    chk("full_ready", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    @(negedge clk);
    chk("reset_ready", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    chk("reset_state", 64'({o_ready, o_valid, o_err, o_ext}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));
    @(posedge clk); #1;
    send_chk("sext", 26'h8001, 3'd0, 32'h0, {1'b0, 32'hFFFF8001});
    send_chk("zext", 26'h8001, 3'd1, 32'h0, {1'b0, 32'h00008001});
    send_chk("lui", 26'h1234, 3'd2, 32'h0, {1'b0, 32'h12340000});
    send_chk("branch_neg", 26'hFFFF, 3'd3, 32'h0, {1'b0, 32'hFFFFFFFC});
    send_chk("branch_pos", 26'h7FFF, 3'd3, 32'h0, {1'b0, 32'h0001FFFC});
    send_chk("jump", 26'h3FFFFFF, 3'd4, 32'hA0000000, {1'b0, 32'hAFFFFFFC});
    send_chk("illegal", 26'h1234, 3'd6, 32'h0, {1'b1, 32'h0});
    send_chk("after_illegal", 26'h1234, 3'd1, 32'h0, {1'b0, 32'h00001234});
    fill_two();
    i_valid = 1'b1; i_field = 26'h0003; i_mode = 3'd0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_low", 64'(o_ready), 64'd0);
      chk("bp_head", 64'(o_ext), 64'h1);
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    send(26'h0003, 3'd0, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", 64'(sb.size()), 64'd0);
    fill_two();
    i_valid = 1'b1; i_field = 26'h0055; i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("flush_state", 64'({o_valid, o_ready}), 64'({1'b0, 1'b1}));
    chk("flush_keep_ext", 64'(o_ext), 64'h1);
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    fill_two();
    i_valid = 1'b1; i_field = 26'h0077; i_reset = 1'b1;
    @(negedge clk);
    chk("rst_ready_low", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
    i_reset = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("rst_state", 64'({o_valid, o_ready, o_err, o_ext}), 64'({1'b0, 1'b1, 1'b0, 32'h0}));
    @(posedge clk); #1;
    i_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      i_valid = $urandom_range(0, 3) != 0;
      i_ready = $urandom_range(0, 2) != 0;
      i_flush = $urandom_range(0, 60) == 0;
      i_field = 26'($urandom);
      i_mode = 3'($urandom_range(0, 7));
      i_pc = $urandom;
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("final_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
